// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared types and constants for the PWM capture block.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_state_t;

    localparam int PWM_NOM_PERIOD = 256;
    localparam int DEGLITCH_LEN   = 3;

endpackage
`default_nettype wire

// File: rtl/pwm_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_sync_edge
//  Description : PWM line synchronizer with optional deglitch filter
//                (PWM_DEGLITCH_EN) and rise/fall pulse generation.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_sync_edge
    import pwm_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pwm,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    logic                   w_level;
    logic                   r_level_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pwm};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PWM_DEGLITCH_EN
    // Level follows the line only once the window is unanimous; r_level_d holds it otherwise.
    logic [DEGLITCH_LEN-2:0] r_hist;
    logic [DEGLITCH_LEN-1:0] w_window;

    assign w_window = {r_hist, w_sync};
    assign w_level  = (&w_window) ? 1'b1 : ((|w_window) ? r_level_d : 1'b0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
        end else begin
            r_hist <= w_window[DEGLITCH_LEN-2:0];
        end
    end
`else
    assign w_level = w_sync;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= w_level;
        end
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_level_d;
    assign o_fall  = ~w_level & r_level_d;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_capture
//  Description : Measures high time and period of an external PWM line and
//                recovers the duty code; flags stuck lines. Optional input
//                deglitch filter enabled by defining PWM_DEGLITCH_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int DUTY_W      = 8,
    parameter int CNT_W       = 10,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_vld,
    output logic [CNT_W-1:0]  period,
    output logic              period_err,
    output logic              stuck_hi,
    output logic              stuck_lo
);

    localparam logic [CNT_W-1:0] c_cnt_max    = '1;
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_nom_period = CNT_W'(2**DUTY_W);
    localparam logic [CNT_W-1:0] c_duty_max   = CNT_W'(2**DUTY_W - 1);
    localparam logic [CNT_W-1:0] c_timeout    = CNT_W'(TIMEOUT);

    logic              w_s;
    logic              w_rise;
    logic              w_fall;
    logic              w_edge;
    logic              w_timeout;
    logic [CNT_W-1:0]  w_high_m1;
    logic [DUTY_W-1:0] w_duty_sat;

    pwm_state_t        r_state;
    logic [CNT_W-1:0]  r_high_cnt;
    logic [CNT_W-1:0]  r_per_cnt;
    logic [CNT_W-1:0]  r_idle_cnt;

    pwm_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .rst     (rst),
        .i_pwm   (pwm_in),
        .o_level (w_s),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_edge     = w_rise | w_fall;
    // Qualified by the flags so a saturated idle counter cannot re-trigger.
    assign w_timeout  = (r_idle_cnt == c_timeout) && !stuck_hi && !stuck_lo;
    assign w_high_m1  = r_high_cnt - c_cnt_one;
    assign w_duty_sat = (w_high_m1 > c_duty_max) ? '1 : w_high_m1[DUTY_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_high_cnt <= '0;
            r_per_cnt  <= '0;
            r_idle_cnt <= '0;
            duty       <= '0;
            duty_vld   <= 1'b0;
            period     <= '0;
            period_err <= 1'b0;
            stuck_hi   <= 1'b0;
            stuck_lo   <= 1'b0;
        end else begin
            duty_vld <= 1'b0;

            if (w_edge) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != c_cnt_max) begin
                r_idle_cnt <= r_idle_cnt + c_cnt_one;
            end

            if (w_rise) begin
                r_per_cnt <= c_cnt_one;
            end else if (r_per_cnt != c_cnt_max) begin
                r_per_cnt <= r_per_cnt + c_cnt_one;
            end

            if (w_rise) begin
                r_high_cnt <= c_cnt_one;
            end else if (r_state == HIGH && !w_fall && r_high_cnt != c_cnt_max) begin
                r_high_cnt <= r_high_cnt + c_cnt_one;
            end

            if (w_edge) begin
                stuck_hi <= 1'b0;
                stuck_lo <= 1'b0;
            end else if (w_timeout) begin
                if (w_s) begin
                    stuck_hi <= 1'b1;
                    duty     <= '1;
                    duty_vld <= 1'b1;
                end else begin
                    stuck_lo <= 1'b1;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= HIGH;
                    end else if (w_fall) begin
                        r_state <= LOW;
                    end
                end
                HIGH: begin
                    if (w_fall) begin
                        r_state <= LOW;
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        r_state <= HIGH;
                        // A rise that ends a stuck-low interval closes no valid period.
                        if (!stuck_lo) begin
                            period     <= r_per_cnt;
                            duty       <= w_duty_sat;
                            period_err <= (r_per_cnt != c_nom_period);
                            duty_vld   <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_capture
//  Description : Directed self-checking bench for pwm_capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        pwm_in;
    logic [7:0]  duty;
    logic        duty_vld;
    logic [9:0]  period;
    logic        period_err;
    logic        stuck_hi;
    logic        stuck_lo;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vld_total = 0;
    int last_vld_cyc = 0;
    int vld_interval = 0;

    pwm_capture #(
        .DUTY_W      (8),
        .CNT_W       (10),
        .SYNC_STAGES (2),
        .TIMEOUT     (512)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .duty       (duty),
        .duty_vld   (duty_vld),
        .period     (period),
        .period_err (period_err),
        .stuck_hi   (stuck_hi),
        .stuck_lo   (stuck_lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (duty_vld === 1'b1) begin
            vld_interval = cyc - last_vld_cyc;
            last_vld_cyc = cyc;
            vld_total    = vld_total + 1;
        end
    end

    task automatic gen(input int hi, input int per);
        pwm_in = 1'b1;
        repeat (hi) @(negedge clk);
        pwm_in = 1'b0;
        repeat (per - hi) @(negedge clk);
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (duty !== 8'h00)     begin errors++; $display("FAIL reset_duty: got %0h want 0", duty); end
        checks++; if (duty_vld !== 1'b0)  begin errors++; $display("FAIL reset_vld: got %0b want 0", duty_vld); end
        checks++; if (period !== 10'd0)   begin errors++; $display("FAIL reset_period: got %0d want 0", period); end
        checks++; if (period_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", period_err); end
        checks++; if (stuck_hi !== 1'b0)  begin errors++; $display("FAIL reset_stuck_hi: got %0b want 0", stuck_hi); end
        checks++; if (stuck_lo !== 1'b0)  begin errors++; $display("FAIL reset_stuck_lo: got %0b want 0", stuck_lo); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_nominal();
        int base;
        base = vld_total;
        repeat (5) gen(65, 256);
        checks++; if (vld_total - base !== 4) begin errors++; $display("FAIL nominal_count: got %0d want 4", vld_total - base); end
        checks++; if (duty !== 8'h40)     begin errors++; $display("FAIL nominal_duty: got %0h want 40", duty); end
        checks++; if (period !== 10'd256) begin errors++; $display("FAIL nominal_period: got %0d want 256", period); end
        checks++; if (period_err !== 1'b0) begin errors++; $display("FAIL nominal_err: got %0b want 0", period_err); end
        checks++; if (vld_interval !== 256) begin errors++; $display("FAIL nominal_interval: got %0d want 256", vld_interval); end
    endtask

    task automatic test_extremes();
        gen(1, 256);
        gen(1, 256);
        checks++; if (duty !== 8'h00) begin errors++; $display("FAIL min_duty: got %0h want 00", duty); end
        gen(255, 256);
        gen(255, 256);
        checks++; if (duty !== 8'hFE)      begin errors++; $display("FAIL max_duty: got %0h want fe", duty); end
        checks++; if (period_err !== 1'b0) begin errors++; $display("FAIL max_err: got %0b want 0", period_err); end
        checks++; if (stuck_hi !== 1'b0)   begin errors++; $display("FAIL max_stuck_hi: got %0b want 0", stuck_hi); end
        checks++; if (stuck_lo !== 1'b0)   begin errors++; $display("FAIL max_stuck_lo: got %0b want 0", stuck_lo); end
    endtask

    task automatic test_short_period();
        gen(50, 200);
        gen(50, 200);
        checks++; if (period !== 10'd200)  begin errors++; $display("FAIL short_period: got %0d want 200", period); end
        checks++; if (period_err !== 1'b1) begin errors++; $display("FAIL short_err: got %0b want 1", period_err); end
        checks++; if (duty !== 8'h31)      begin errors++; $display("FAIL short_duty: got %0h want 31", duty); end
    endtask

    task automatic test_reset_mid_high();
        int base;
        pwm_in = 1'b1;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (duty !== 8'h00)      begin errors++; $display("FAIL midrst_duty: got %0h want 0", duty); end
        checks++; if (period !== 10'd0)    begin errors++; $display("FAIL midrst_period: got %0d want 0", period); end
        checks++; if (period_err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %0b want 0", period_err); end
        repeat (3) @(negedge clk);
        pwm_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        base = vld_total;
        gen(100, 256);
        gen(100, 256);
        checks++; if (vld_total - base !== 1) begin errors++; $display("FAIL midrst_count: got %0d want 1", vld_total - base); end
        checks++; if (duty !== 8'h63)      begin errors++; $display("FAIL midrst_duty_after: got %0h want 63", duty); end
        checks++; if (period !== 10'd256)  begin errors++; $display("FAIL midrst_period_after: got %0d want 256", period); end
        checks++; if (period_err !== 1'b0) begin errors++; $display("FAIL midrst_err_after: got %0b want 0", period_err); end
`ifdef PWM_DEGLITCH_EN
        pwm_in = 1'b1;
        repeat (40) @(negedge clk);
        pwm_in = 1'b0;
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (59) @(negedge clk);
        pwm_in = 1'b0;
        repeat (156) @(negedge clk);
        gen(100, 256);
        checks++; if (duty !== 8'h63)     begin errors++; $display("FAIL glitch_duty: got %0h want 63", duty); end
        checks++; if (period !== 10'd256) begin errors++; $display("FAIL glitch_period: got %0d want 256", period); end
`endif
    endtask

    task automatic test_stuck_lo();
        int base;
        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        base = vld_total;
        repeat (505) @(negedge clk);
        checks++; if (stuck_lo !== 1'b0) begin errors++; $display("FAIL stuck_lo_early: got %0b want 0", stuck_lo); end
        repeat (15) @(negedge clk);
        checks++; if (stuck_lo !== 1'b1) begin errors++; $display("FAIL stuck_lo_set: got %0b want 1", stuck_lo); end
        checks++; if (duty !== 8'h00)    begin errors++; $display("FAIL stuck_lo_duty: got %0h want 0", duty); end
        pwm_in = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (stuck_lo !== 1'b0) begin errors++; $display("FAIL stuck_lo_clear: got %0b want 0", stuck_lo); end
        checks++; if (vld_total - base !== 0) begin errors++; $display("FAIL stuck_lo_vld: got %0d want 0", vld_total - base); end
    endtask

    task automatic test_stuck_hi();
        int base;
        base = vld_total;
        repeat (490) @(negedge clk);
        checks++; if (stuck_hi !== 1'b0) begin errors++; $display("FAIL stuck_hi_early: got %0b want 0", stuck_hi); end
        repeat (30) @(negedge clk);
        checks++; if (stuck_hi !== 1'b1)  begin errors++; $display("FAIL stuck_hi_set: got %0b want 1", stuck_hi); end
        checks++; if (duty !== 8'hFF)     begin errors++; $display("FAIL stuck_hi_duty: got %0h want ff", duty); end
        checks++; if (period !== 10'd0)   begin errors++; $display("FAIL stuck_hi_period: got %0d want 0", period); end
        checks++; if (vld_total - base !== 1) begin errors++; $display("FAIL stuck_hi_vld: got %0d want 1", vld_total - base); end
        pwm_in = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (stuck_hi !== 1'b0) begin errors++; $display("FAIL stuck_hi_clear: got %0b want 0", stuck_hi); end
    endtask

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_nominal();
        test_extremes();
        test_short_period();
        test_reset_mid_high();
        test_stuck_lo();
        test_stuck_hi();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
